// File: rtl/cmp_pkg.sv
// Shared types and helpers for the RISC-V branch/SLT compare unit.
package cmp_pkg;

    localparam int CMP_MAX_STAGES = 4;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NE   = 3'b001,
        CMP_RSV2 = 3'b010,
        CMP_RSV3 = 3'b011,
        CMP_LT   = 3'b100,
        CMP_GE   = 3'b101,
        CMP_LTU  = 3'b110,
        CMP_GEU  = 3'b111
    } cmp_op_e;

    function automatic logic is_signed(input cmp_op_e op);
        return (op == CMP_LT) || (op == CMP_GE);
    endfunction

    function automatic logic is_reserved(input cmp_op_e op);
        return (op == CMP_RSV2) || (op == CMP_RSV3);
    endfunction

    // Maps the unsigned eq/lt pair onto the requested condition; reserved ops read as false.
    function automatic logic cmp_flag(input cmp_op_e op, input logic eq, input logic lt);
        logic f;
        case (op)
            CMP_EQ:  f = eq;
            CMP_NE:  f = ~eq;
            CMP_LT:  f = lt;
            CMP_GE:  f = ~lt;
            CMP_LTU: f = lt;
            CMP_GEU: f = ~lt;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// One elastic pipeline slice: a valid bit plus a W-bit payload with load enable and flush.
module cmp_pipe_stage
    import cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // Payload only moves on a real beat so a held or drained slice keeps its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cmp_unit.sv
// Pipelined branch-condition / SLT compare unit with valid/ready back-pressure,
// in-order tag sideband and synchronous flush.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             flag_o,
    output logic [XLEN-1:0]  result_o,
    output logic             err_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int H   = XLEN / 2;
    localparam int PW1 = 3 + TAG_W + 4;  // {op, tag, eq_hi, lt_hi, eq_lo, lt_lo}
    localparam int PW2 = TAG_W + 2;      // {tag, flag, err}

    if ((XLEN % 2) != 0 || XLEN < 8) begin : g_chk_xlen
        $error("cmp_unit: XLEN must be even and at least 8");
    end
    if (STAGES < 1 || STAGES > CMP_MAX_STAGES) begin : g_chk_stages
        $error("cmp_unit: STAGES must be within 1..CMP_MAX_STAGES");
    end

    cmp_op_e         op_in;
    logic [XLEN-1:0] a_m, b_m;
    logic            eq_hi, lt_hi, eq_lo, lt_lo;

    // Flipping both MSBs turns a signed order into an unsigned one, so no subtractor is needed.
    always_comb begin
        op_in = cmp_op_e'(op_i);
        a_m   = a_i;
        b_m   = b_i;
        if (is_signed(op_in)) begin
            a_m[XLEN-1] = ~a_i[XLEN-1];
            b_m[XLEN-1] = ~b_i[XLEN-1];
        end
        eq_hi = (a_m[XLEN-1:H] == b_m[XLEN-1:H]);
        lt_hi = (a_m[XLEN-1:H] <  b_m[XLEN-1:H]);
        eq_lo = (a_m[H-1:0] == b_m[H-1:0]);
        lt_lo = (a_m[H-1:0] <  b_m[H-1:0]);
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic              adv_c;

    // A slice may load when it is empty or the slice after it is advancing too.
    always_comb begin
        adv_c           = ~vld[STAGES-1] | ready_i;
        adv             = '0;
        adv[STAGES-1]   = adv_c;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv_c  = ~vld[k] | adv_c;
            adv[k] = adv_c;
        end
    end

    logic [PW2-1:0] tail_pl;

    if (STAGES == 1) begin : g_one
        logic           eq_full, lt_full;
        logic [PW2-1:0] pl_d;

        always_comb begin
            eq_full = eq_hi & eq_lo;
            lt_full = lt_hi | (eq_hi & lt_lo);
            pl_d    = {tag_i, cmp_flag(op_in, eq_full, lt_full), is_reserved(op_in)};
        end

        cmp_pipe_stage #(.W(PW2)) u_st0 (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_i),
            .load_i  (adv[0]),
            .valid_i (valid_i),
            .data_i  (pl_d),
            .valid_o (vld[0]),
            .data_o  (tail_pl)
        );
    end else begin : g_multi
        logic [PW1-1:0]   p1_d, p1_q;
        logic [PW2-1:0]   p2_d;
        logic [PW2-1:0]   pl_q [1:STAGES-1];
        cmp_op_e          op_p1;
        logic [TAG_W-1:0] tag_p1;
        logic             eq_p1, lt_p1;

        assign p1_d = {op_i, tag_i, eq_hi, lt_hi, eq_lo, lt_lo};

        cmp_pipe_stage #(.W(PW1)) u_st0 (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_i),
            .load_i  (adv[0]),
            .valid_i (valid_i),
            .data_i  (p1_d),
            .valid_o (vld[0]),
            .data_o  (p1_q)
        );

        // Second stage folds the half-word results into one eq/lt pair and decodes the condition.
        always_comb begin
            op_p1  = cmp_op_e'(p1_q[PW1-1 -: 3]);
            tag_p1 = p1_q[4 +: TAG_W];
            eq_p1  = p1_q[3] & p1_q[1];
            lt_p1  = p1_q[2] | (p1_q[3] & p1_q[0]);
            p2_d   = {tag_p1, cmp_flag(op_p1, eq_p1, lt_p1), is_reserved(op_p1)};
        end

        for (genvar k = 1; k < STAGES; k++) begin : g_st
            logic [PW2-1:0] din;

            if (k == 1) begin : g_first
                assign din = p2_d;
            end else begin : g_delay
                assign din = pl_q[k-1];
            end

            cmp_pipe_stage #(.W(PW2)) u_st (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush_i (flush_i),
                .load_i  (adv[k]),
                .valid_i (vld[k-1]),
                .data_i  (din),
                .valid_o (vld[k]),
                .data_o  (pl_q[k])
            );
        end

        assign tail_pl = pl_q[STAGES-1];
    end

    assign ready_o  = adv[0];
    assign valid_o  = vld[STAGES-1];
    assign tag_o    = tail_pl[PW2-1 -: TAG_W];
    assign flag_o   = tail_pl[1];
    assign err_o    = tail_pl[0];
    assign result_o = {{(XLEN-1){1'b0}}, tail_pl[1]};

endmodule

// File: doc/cmp_unit.md
# cmp_unit

Parametrised, pipelined compare unit for the RISC-V integer datapath: evaluates all six branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the SLT/SLTU result for XLEN-wide operands. Replaces the single-cycle combinational less-than block. Adds signed/unsigned mode selection, a configurable pipeline depth with valid/ready back-pressure, an in-order tag sideband and a synchronous flush. Sits between the issue stage and the ALU/branch writeback mux.

## Interface
- XLEN, 32: operand width; even, ≥ 8.
- STAGES, 2: pipeline depth, 1..4.
- TAG_W, 5: sideband tag width (e.g. rd index).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  drops every in-flight entry.
- valid_i  in  1  request valid.
- ready_o  out  1  unit accepts request this cycle.
- op_i  in  3  condition, RISC-V funct3 encoding.
- a_i, b_i  in  XLEN  operands.
- tag_i  in  TAG_W  sideband, returned unchanged.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- flag_o  out  1  condition true.
- result_o  out  XLEN  {XLEN-1 zeros, flag_o}; SLT/SLTU writeback value.
- err_o  out  1  reserved op; qualified by valid_o.
- tag_o  out  TAG_W  tag of the current result.

## Operation
- op encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010/011 are reserved: flag_o=0, err_o=1.
- Signed ops invert the MSB of both operands, then compare unsigned. No subtraction is used.
- Compare split, STAGES ≥ 2:
  - Stage 1 registers, per half (high and low, XLEN/2 bits each): eq_hi, lt_hi, eq_lo, lt_lo. It also registers op and tag.
  - Stage 2 combines: lt = lt_hi | (eq_hi & lt_lo); eq = eq_hi & eq_lo.
  - Stages 3..STAGES are pure delay slices.
- STAGES=1: the full compare is computed before the single register.
- Each stage is an elastic slice holding a valid bit plus payload.
  - adv[STAGES-1] = ~v[STAGES-1] | ready_i.
  - adv[k] = ~v[k] | adv[k+1].
  - ready_o = adv[0].
  - A slice loads when adv[k] is high.
- Results are strictly in order. There is no reordering or dropping except by flush.
- flush_i clears all valid bits at the next edge. A request presented in the same cycle is discarded, even if ready_o=1.
- Reset (async assert): all valid bits 0; payload registers 0.
  - Therefore valid_o=0, flag_o=0, result_o=0, err_o=0, tag_o=0, and ready_o=1 while out of reset.

## Timing
- Latency: STAGES cycles from accept (valid_i & ready_o) to valid_o, with no stall.
- Throughput: one request per cycle while ready_i=1.
- valid_o stays high with payload stable until ready_i. Payload must not change while valid_o & ~ready_i.
- ready_o depends combinationally on ready_i through the adv chain. It never depends on valid_i.
- Full pipe with ready_i=0: ready_o=0. When ready_i rises, ready_o=1 in the same cycle.
- Simultaneous flush_i & ready_i & valid_o: the output beat counts as consumed. The pipe is empty the next cycle.
- Reset deasserted mid-stream: the pipe is empty; the first accept is possible in the first cycle after deassertion.

## Structure
- Package cmp_pkg:
  - cmp_op_e enum holding the six ops plus the reserved values.
  - Helper is_signed(op).
  - Constant CMP_MAX_STAGES=4.
- Sub-module cmp_pipe_stage: one elastic slice (valid, payload of parameter width, load enable, flush). Instantiated STAGES times via generate.
- Parameter checks use elaboration-time assertions: XLEN even and ≥ 8; STAGES in 1..4.

## Test plan
- Signed boundary: LT with a=0x80000000, b=0x7FFFFFFF → flag_o=1, result_o=1. LTU with the same operands → flag_o=0. GE with a=b=0xFFFFFFFF → flag_o=1.
- Half-split carry: LTU with a=0x0001FFFF, b=0x00020000 → 1. EQ with a=0x12345678, b=0x12345679 → 0. NE with the same operands → 1.
- Latency/throughput: STAGES=2, ready_i=1, 8 back-to-back requests with tags 0..7 → first valid_o 2 cycles after the first accept, then one result per cycle, tags 0..7 in order.
- Back-pressure: fill the pipe with ready_i=0 → ready_o=0 after STAGES accepts. Hold 5 cycles → outputs stable. Release → all entries drain in order with no loss.
- Flush: 2 entries in flight, flush_i with valid_i=1 → valid_o=0 next cycle. The flushed request never appears.
- Reserved op 011 → err_o=1, flag_o=0 with valid_o. Async reset mid-stream → all outputs 0 immediately and ready_o=1 after release.
